debug_port_sched: RTL and testbench
===================================

// Module: debug_port_sched
// PURPOSE
//  - Frame-synchronous scheduler sharing the 8-bit bidir debug port (uio_out/uio_oe) among
//    four 8-bit debug sources: LZC result, raw RGB/visible taps, and two spares.
//  - Source changes take effect only at the vsync assertion edge, so a scope or logic
//    analyser never sees a mid-frame mix of sources.
//  - Selection is manual (driven from ui_in) or auto-rotating every N frames.
//  - Sits between the game core / LZC outputs and the top-level uio pins.
// PARAMETERS
//  FRAMES_PER_SLOT   60  frames each source stays selected in auto mode (>=1)
//  GUARD_CYCLES      8   clocks of blanked output after every source switch (>=1)
//  VSYNC_ACTIVE_LOW  1   1: vsync asserted low; 0: vsync asserted high
// PORTS
//  clk          in   1  pixel clock (25.175 MHz nominal)
//  rst_n        in   1  synchronous active-low reset
//  vsync        in   1  vsync from game core, polarity set by VSYNC_ACTIVE_LOW
//  src0..src3   in   8  debug sources; src0 is the default after reset
//  sel_in       in   2  manual source select, sampled only on frame_tick
//  auto_en      in   1  1 = auto-rotate mode, 0 = manual mode
//  uio_out      out  8  registered output of the selected source
//  uio_oe       out  8  pin output enables
//  cur_sel      out  2  currently applied source index
//  switch_pulse out  1  one-clock pulse on the cycle a switch is applied
// BEHAVIOUR
//  - Reset (sync, rst_n low at posedge clk): uio_out=0, uio_oe=8'h00, cur_sel=0,
//    switch_pulse=0, frame_cnt=0, vsync_q=deasserted level, state=RUN.
//    Reset asserted mid-GUARD aborts the guard interval immediately.
//  - uio_oe=8'hFF from the first clock after reset release onward.
//  - frame_tick: single-cycle strobe on the deasserted->asserted vsync edge. Detected from
//    registered vsync_q vs current vsync. No extra sync stage; vsync is clk-domain.
//  - frame_cnt: width $clog2(FRAMES_PER_SLOT+1). Increments on frame_tick. Wraps to 0 at
//    FRAMES_PER_SLOT-1. Held at 0 while auto_en=0.
//  - next_sel on frame_tick:
//      auto_en=1: cur_sel+1 (2-bit wrap 3->0) if frame_cnt==FRAMES_PER_SLOT-1, else cur_sel
//      auto_en=0: sel_in
//  - FSM states: RUN, GUARD.
//    RUN:   on frame_tick with next_sel!=cur_sel -> cur_sel<=next_sel, switch_pulse=1,
//           guard_cnt<=GUARD_CYCLES-1, go to GUARD.
//           On frame_tick with next_sel==cur_sel -> stay in RUN, no pulse.
//    GUARD: uio_out = blank value. guard_cnt decrements each clock; at 0 go to RUN.
//           A frame_tick in GUARD still advances frame_cnt but never changes cur_sel.
//  - RUN output: uio_out <= src[cur_sel], latency exactly 1 clock from src change.
//  - Mid-frame changes of sel_in or auto_en have no effect until the next frame_tick.
//    Toggling auto_en 1->0 clears frame_cnt on the next clock.
//  - vsync held asserted produces no further ticks; only a new edge counts.
// CONFIGURATION
//  - DEBUG_SCHED_TAG_EN defined: the GUARD blank value is the tag {4'hA, 2'b00, cur_sel},
//    identifying the new source on the analyser.
//  - DEBUG_SCHED_TAG_EN undefined: the GUARD blank value is 8'h00.
//  - All other behaviour is identical in both builds.
// TESTING
//  1. rst_n low 3 clks, then high -> uio_out=0, cur_sel=0; uio_oe=00 during reset,
//     FF from 1st clk after release.
//  2. Manual, sel_in=2 mid-frame -> cur_sel stays 0 until vsync edge. At edge: switch_pulse
//     for 1 clk, 8 clks of 00 (A2 with TAG_EN), then uio_out=src2 value 1 clk after change.
//  3. Auto, FRAMES_PER_SLOT=3 -> cur_sel 0,0,0,1,1,1,2,2,2,3,3,3,0 across 13 vsync edges.
//     Exactly 4 switch_pulses.
//  4. sel_in=cur_sel at vsync edge -> no pulse, no guard, output uninterrupted.
//  5. Two vsync edges 5 clks apart (GUARD_CYCLES=8) -> second edge ignored for selection;
//     frame_cnt still advances in auto mode.
//  6. rst_n low during GUARD -> next clk uio_out=0, cur_sel=0, state RUN.
//     VSYNC_ACTIVE_LOW=0 -> tick occurs on the rising edge instead.

Source files
------------

// File: rtl/debug_port_sched.sv
// Frame-synchronous scheduler that multiplexes four debug sources onto the uio pins.
// Optional build macro DEBUG_SCHED_TAG_EN: drive a source-identifying tag during the guard blank.
module debug_port_sched #(
    parameter int FRAMES_PER_SLOT  = 60,
    parameter int GUARD_CYCLES     = 8,
    parameter bit VSYNC_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vsync,
    input  logic [7:0] src0,
    input  logic [7:0] src1,
    input  logic [7:0] src2,
    input  logic [7:0] src3,
    input  logic [1:0] sel_in,
    input  logic       auto_en,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    output logic [1:0] cur_sel,
    output logic       switch_pulse
);

    localparam int FCW = $clog2(FRAMES_PER_SLOT + 1);
    localparam int GCW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [FCW-1:0] FRAME_LAST = FCW'(FRAMES_PER_SLOT - 1);
    localparam logic [GCW-1:0] GUARD_LOAD = GCW'(GUARD_CYCLES - 1);
    localparam logic           VSYNC_IDLE = VSYNC_ACTIVE_LOW;

    typedef enum logic {RUN, GUARD} state_t;

    state_t         state, state_n;
    logic [GCW-1:0] guard_cnt, guard_n;
    logic [FCW-1:0] frame_cnt, frame_n;
    logic [1:0]     sel_n, next_sel;
    logic           pulse_n;
    logic [7:0]     out_n;
    logic           vsync_q;
    logic           frame_tick;

    function automatic logic [7:0] blank_value(input logic [1:0] sel);
`ifdef DEBUG_SCHED_TAG_EN
        return {4'hA, 2'b00, sel};
`else
        return 8'h00 | {6'b0, sel & 2'b00};
`endif
    endfunction

    function automatic logic [7:0] src_mux(input logic [1:0] sel,
                                           input logic [7:0] s0, input logic [7:0] s1,
                                           input logic [7:0] s2, input logic [7:0] s3);
        case (sel)
            2'd0:    return s0;
            2'd1:    return s1;
            2'd2:    return s2;
            default: return s3;
        endcase
    endfunction

    // Edge detect on the asserted level only; vsync is already in the clk domain.
    assign frame_tick = (vsync != VSYNC_IDLE) && (vsync_q == VSYNC_IDLE);

    always_comb begin
        frame_n = frame_cnt;
        if (!auto_en)
            frame_n = '0;
        else if (frame_tick)
            frame_n = (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + 1'b1;
    end

    always_comb begin
        next_sel = sel_in;
        if (auto_en)
            next_sel = (frame_cnt == FRAME_LAST) ? cur_sel + 2'd1 : cur_sel;
    end

    always_comb begin
        state_n = state;
        guard_n = guard_cnt;
        sel_n   = cur_sel;
        pulse_n = 1'b0;
        case (state)
            RUN: begin
                if (frame_tick && (next_sel != cur_sel)) begin
                    sel_n   = next_sel;
                    pulse_n = 1'b1;
                    guard_n = GUARD_LOAD;
                    state_n = GUARD;
                end
            end
            GUARD: begin
                if (guard_cnt == '0)
                    state_n = RUN;
                else
                    guard_n = guard_cnt - 1'b1;
            end
            default: state_n = RUN;
        endcase
        // Blank from the switching clock itself so no stale sample follows the pulse.
        out_n = (state_n == GUARD) ? blank_value(sel_n)
                                   : src_mux(sel_n, src0, src1, src2, src3);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= RUN;
            guard_cnt    <= '0;
            frame_cnt    <= '0;
            cur_sel      <= 2'd0;
            switch_pulse <= 1'b0;
            vsync_q      <= VSYNC_IDLE;
            uio_out      <= 8'h00;
            uio_oe       <= 8'h00;
        end else begin
            state        <= state_n;
            guard_cnt    <= guard_n;
            frame_cnt    <= frame_n;
            cur_sel      <= sel_n;
            switch_pulse <= pulse_n;
            vsync_q      <= vsync;
            uio_out      <= out_n;
            uio_oe       <= 8'hFF;
        end
    end

endmodule

// File: tb/tb_debug_port_sched.sv
// Scoreboard bench for debug_port_sched: stimulus queues expected switches, a monitor checks them.
module tb_debug_port_sched;

    logic       clk = 1'b0;
    logic       rst_n, vsync, vsync_h, auto_en, auto_en_h;
    logic [7:0] src0, src1, src2, src3;
    logic [1:0] sel_in, sel_in_h;
    logic [7:0] uio_out, uio_oe, uio_out_h, uio_oe_h;
    logic [1:0] cur_sel, cur_sel_h;
    logic       switch_pulse, switch_pulse_h;

    always #5 clk = ~clk;

    debug_port_sched #(.FRAMES_PER_SLOT(3), .GUARD_CYCLES(8), .VSYNC_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .vsync(vsync),
        .src0(src0), .src1(src1), .src2(src2), .src3(src3),
        .sel_in(sel_in), .auto_en(auto_en),
        .uio_out(uio_out), .uio_oe(uio_oe), .cur_sel(cur_sel), .switch_pulse(switch_pulse)
    );

    debug_port_sched #(.FRAMES_PER_SLOT(3), .GUARD_CYCLES(8), .VSYNC_ACTIVE_LOW(1'b0)) dut_h (
        .clk(clk), .rst_n(rst_n), .vsync(vsync_h),
        .src0(src0), .src1(src1), .src2(src2), .src3(src3),
        .sel_in(sel_in_h), .auto_en(auto_en_h),
        .uio_out(uio_out_h), .uio_oe(uio_oe_h), .cur_sel(cur_sel_h), .switch_pulse(switch_pulse_h)
    );

    typedef struct {
        logic [1:0] sel;
        int         guard;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   pulses = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] blank(input logic [1:0] sel);
`ifdef DEBUG_SCHED_TAG_EN
        return {4'hA, 2'b00, sel};
`else
        return (sel == 2'd0) ? 8'h00 : 8'h00;
`endif
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic tick();
        vsync = 1'b0;
        step(1);
        vsync = 1'b1;
    endtask

    task automatic push(input logic [1:0] sel, input int guard);
        exp_t e;
        e.sel   = sel;
        e.guard = guard;
        q.push_back(e);
    endtask

    // Monitor: every switch pulse must match the oldest queued expectation.
    initial begin
        exp_t e;
        int   n;
        forever begin
            @(negedge clk);
            if (switch_pulse === 1'b1) begin
                pulses++;
                chk("pulse_expected", 32'(q.size() > 0), 32'd1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("switch_sel", 32'(cur_sel), 32'(e.sel));
                    chk("switch_blank", 32'(uio_out), 32'(blank(e.sel)));
                    if (e.guard > 0) begin
                        n = 1;
                        for (int k = 0; k < 20; k++) begin
                            @(negedge clk);
                            if (uio_out === blank(e.sel)) n++;
                            else break;
                        end
                        chk("guard_len", 32'(n), 32'(e.guard));
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    logic [1:0] before_tbl [13] = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3,
                                    2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd1};

    initial begin
        int p0;
        rst_n = 1'b0; vsync = 1'b1; vsync_h = 1'b0;
        auto_en = 1'b0; auto_en_h = 1'b0; sel_in = 2'd0; sel_in_h = 2'd3;
        src0 = 8'h11; src1 = 8'h22; src2 = 8'h33; src3 = 8'h44;

        // Reset and release
        step(3);
        at_neg();
        chk("rst_oe", 32'(uio_oe), 32'h00);
        chk("rst_out", 32'(uio_out), 32'h00);
        chk("rst_sel", 32'(cur_sel), 32'd0);
        rst_n = 1'b1;
        step(1);
        at_neg();
        chk("rel_oe", 32'(uio_oe), 32'hFF);
        chk("rel_out", 32'(uio_out), 32'h11);

        // Manual select takes effect only at the vsync edge
        sel_in = 2'd2;
        step(5);
        at_neg();
        chk("mid_frame_sel", 32'(cur_sel), 32'd0);
        chk("mid_frame_out", 32'(uio_out), 32'h11);
        push(2'd2, 8);
        tick();
        step(11);
        at_neg();
        chk("after_guard_out", 32'(uio_out), 32'h33);
        chk("after_guard_sel", 32'(cur_sel), 32'd2);
        step(1);
        src2 = 8'h5C;
        at_neg();
        chk("lat_before", 32'(uio_out), 32'h33);
        step(1);
        at_neg();
        chk("lat_after", 32'(uio_out), 32'h5C);

        // Same selection at the edge: no pulse, no blanking
        p0 = pulses;
        tick();
        for (int i = 0; i < 12; i++) begin
            at_neg();
            chk("no_switch_out", 32'(uio_out), 32'h5C);
            step(1);
        end
        chk("no_switch_pulses", 32'(pulses - p0), 32'd0);

        // Second edge inside the guard window is ignored
        sel_in = 2'd1;
        push(2'd1, 8);
        tick();
        sel_in = 2'd3;
        step(3);
        tick();
        sel_in = 2'd1;
        step(12);
        at_neg();
        chk("guard_tick_sel", 32'(cur_sel), 32'd1);
        chk("guard_tick_out", 32'(uio_out), 32'h22);

        // Auto rotation, three frames per slot
        auto_en = 1'b1;
        step(2);
        p0 = pulses;
        for (int i = 0; i < 13; i++) begin
            at_neg();
            chk("auto_sel", 32'(cur_sel), 32'(before_tbl[i]));
            if (i < 12 && before_tbl[i+1] != before_tbl[i])
                push(before_tbl[i+1], 8);
            step(1);
            tick();
            step(11);
        end
        chk("auto_pulses", 32'(pulses - p0), 32'd4);

        // Tick inside guard still advances frame_cnt in auto mode
        tick(); step(11);
        push(2'd2, 8);
        tick(); step(3);
        tick(); step(11);
        tick(); step(11);
        at_neg();
        chk("auto_guard_sel", 32'(cur_sel), 32'd2);
        push(2'd3, 8);
        tick(); step(11);
        at_neg();
        chk("auto_guard_switch", 32'(cur_sel), 32'd3);

        // Leaving auto mode clears frame_cnt
        tick(); step(11);
        auto_en = 1'b0; sel_in = 2'd3;
        step(2);
        auto_en = 1'b1;
        step(1);
        tick(); step(11);
        tick(); step(11);
        at_neg();
        chk("clear_cnt_sel", 32'(cur_sel), 32'd3);
        push(2'd0, 8);
        tick(); step(11);
        at_neg();
        chk("clear_cnt_switch", 32'(cur_sel), 32'd0);

        // Reset inside the guard window
        step(1);
        auto_en = 1'b0; sel_in = 2'd2;
        push(2'd2, 0);
        tick();
        step(2);
        rst_n = 1'b0;
        step(1);
        at_neg();
        chk("grst_out", 32'(uio_out), 32'h00);
        chk("grst_sel", 32'(cur_sel), 32'd0);
        chk("grst_oe", 32'(uio_oe), 32'h00);
        step(1);
        rst_n = 1'b1;
        step(1);
        at_neg();
        chk("grst_run_out", 32'(uio_out), 32'h11);
        chk("queue_empty", 32'(q.size()), 32'd0);

        // Active-high vsync instance ticks on the rising edge only
        step(1);
        vsync_h = 1'b1;
        step(1);
        at_neg();
        chk("hi_pulse", 32'(switch_pulse_h), 32'd1);
        chk("hi_sel", 32'(cur_sel_h), 32'd3);
        step(12);
        at_neg();
        chk("hi_held_no_pulse", 32'(switch_pulse_h), 32'd0);
        chk("hi_out", 32'(uio_out_h), 32'h44);
        sel_in_h = 2'd1;
        step(1);
        vsync_h = 1'b0;
        step(12);
        at_neg();
        chk("hi_fall_ignored", 32'(cur_sel_h), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
